// File: rtl/usb_packet_decoder.sv
// Receive-side USB packet decoder: PID classification and integrity, token CRC5 with
// address/endpoint filter, DATA0/1 payload streaming with CRC16 stripped and checked.
//
// state  | meaning
// IDLE   | bus idle, waiting for rx_active
// PID    | packet started, waiting for the PID byte
// TOK0   | token: waiting for {endp[0], addr}
// TOK1   | token: waiting for {crc5, endp[3:1]}
// EOP    | token/handshake complete, waiting for rx_active to fall
// DATA   | data packet: payload plus CRC16 through the 2-byte delay line
// DROP   | discard everything until rx_active falls
module usb_packet_decoder #(
    parameter int MAX_PACKET    = 8,
    parameter int NUM_ENDPOINTS = 3,
    parameter bit ADDR_FILTER   = 1'b1,
    localparam int LEN_W        = $clog2(MAX_PACKET + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_active,
    input  logic             rx_valid,
    input  logic             rx_error,
    input  logic [6:0]       dev_address,
    output logic [3:0]       pid,
    output logic             pid_valid,
    output logic [6:0]       address,
    output logic [3:0]       end_point,
    output logic             token_valid,
    output logic [7:0]       data_o,
    output logic             data_o_valid,
    output logic [LEN_W-1:0] data_len,
    output logic             data_done,
    output logic             crc_error,
    output logic             pid_error,
    output logic             pkt_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_TOK0,
        S_TOK1,
        S_EOP,
        S_DATA,
        S_DROP
    } state_t;

    // Counter must reach MAX_PACKET+3 so the overflowing byte is still representable.
    localparam int CNT_W = $clog2(MAX_PACKET + 4);
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b00110;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    state_t           state;
    logic             seen_idle;
    logic             is_token;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       hold0;
    logic [7:0]       hold1;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic [6:0]       tok_addr;
    logic [3:0]       tok_ep;

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 5'b10100;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [3:0]       rx_pid;
    logic             pid_ok;
    logic             pid_is_token;
    logic             pid_is_data;
    logic             pid_is_hs;
    logic             ep_ok;
    logic             addr_ok;
    logic [CNT_W-1:0] cnt_next;
    logic             overflow;

    assign rx_pid       = rx_data[3:0];
    assign pid_ok       = (rx_data[7:4] == ~rx_data[3:0]);
    // PING shares the token layout even though it sits in the special PID group.
    assign pid_is_token = (rx_pid[1:0] == 2'b01) || (rx_pid == 4'h4);
    assign pid_is_data  = (rx_pid == 4'h3) || (rx_pid == 4'hB);
    assign pid_is_hs    = (rx_pid[1:0] == 2'b10);
    assign ep_ok        = ({28'd0, tok_ep} < 32'(NUM_ENDPOINTS));
    assign addr_ok      = !ADDR_FILTER || (tok_addr == dev_address);
    assign cnt_next     = byte_cnt + CNT_W'(1);
    assign overflow     = (cnt_next > CNT_W'(MAX_PACKET + 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            seen_idle    <= 1'b0;
            is_token     <= 1'b0;
            byte_cnt     <= '0;
            hold0        <= '0;
            hold1        <= '0;
            crc5         <= '0;
            crc16        <= '0;
            tok_addr     <= '0;
            tok_ep       <= '0;
            pid          <= '0;
            pid_valid    <= 1'b0;
            address      <= '0;
            end_point    <= '0;
            token_valid  <= 1'b0;
            data_o       <= '0;
            data_o_valid <= 1'b0;
            data_len     <= '0;
            data_done    <= 1'b0;
            crc_error    <= 1'b0;
            pid_error    <= 1'b0;
            pkt_error    <= 1'b0;
        end else begin
            pid_valid    <= 1'b0;
            token_valid  <= 1'b0;
            data_o_valid <= 1'b0;
            data_done    <= 1'b0;
            crc_error    <= 1'b0;
            pid_error    <= 1'b0;
            pkt_error    <= 1'b0;
            if (!rx_active) seen_idle <= 1'b1;

            if (state != S_IDLE && state != S_DROP && rx_error) begin
                pkt_error <= 1'b1;
                state     <= S_DROP;
            end else begin
                case (state)
                    S_IDLE: begin
                        // A packet already in flight at reset release is never decoded.
                        if (rx_active) state <= seen_idle ? S_PID : S_DROP;
                    end
                    S_PID: begin
                        if (!rx_active) begin
                            state <= S_IDLE;
                        end else if (rx_valid) begin
                            byte_cnt <= '0;
                            crc5     <= 5'h1F;
                            crc16    <= 16'hFFFF;
                            is_token <= pid_is_token;
                            if (!pid_ok) begin
                                pid_error <= 1'b1;
                                state     <= S_DROP;
                            end else begin
                                pid       <= rx_pid;
                                pid_valid <= 1'b1;
                                if (pid_is_token)     state <= S_TOK0;
                                else if (pid_is_data) state <= S_DATA;
                                else if (pid_is_hs)   state <= S_EOP;
                                else                  state <= S_DROP;
                            end
                        end
                    end
                    S_TOK0: begin
                        if (!rx_active) begin
                            pkt_error <= 1'b1;
                            state     <= S_IDLE;
                        end else if (rx_valid) begin
                            tok_addr  <= rx_data[6:0];
                            tok_ep[0] <= rx_data[7];
                            crc5      <= crc5_byte(crc5, rx_data);
                            state     <= S_TOK1;
                        end
                    end
                    S_TOK1: begin
                        if (!rx_active) begin
                            pkt_error <= 1'b1;
                            state     <= S_IDLE;
                        end else if (rx_valid) begin
                            tok_ep[3:1] <= rx_data[2:0];
                            crc5        <= crc5_byte(crc5, rx_data);
                            state       <= S_EOP;
                        end
                    end
                    S_EOP: begin
                        if (!rx_active) begin
                            state <= S_IDLE;
                            if (is_token) begin
                                if (crc5 != CRC5_RESIDUAL) begin
                                    crc_error <= 1'b1;
                                end else if (ep_ok && addr_ok) begin
                                    token_valid <= 1'b1;
                                    address     <= tok_addr;
                                    end_point   <= tok_ep;
                                end
                            end
                        end else if (rx_valid) begin
                            pkt_error <= 1'b1;
                            state     <= S_DROP;
                        end
                    end
                    S_DATA: begin
                        if (!rx_active) begin
                            state <= S_IDLE;
                            if (byte_cnt < CNT_W'(2)) begin
                                pkt_error <= 1'b1;
                            end else begin
                                data_done <= 1'b1;
                                data_len  <= LEN_W'(byte_cnt - CNT_W'(2));
                                crc_error <= (crc16 != CRC16_RESIDUAL);
                            end
                        end else if (rx_valid) begin
                            if (overflow) begin
                                pkt_error <= 1'b1;
                                state     <= S_DROP;
                            end else begin
                                // The newest two bytes may be the CRC16, so only older ones leave.
                                if (byte_cnt >= CNT_W'(2)) begin
                                    data_o       <= hold1;
                                    data_o_valid <= 1'b1;
                                end
                                hold1    <= hold0;
                                hold0    <= rx_data;
                                byte_cnt <= cnt_next;
                                crc16    <= crc16_byte(crc16, rx_data);
                            end
                        end
                    end
                    S_DROP: begin
                        if (!rx_active) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_packet_decoder.sv
// Directed bench for usb_packet_decoder: default instance plus a 16-endpoint instance
// fed with the same byte stream.
module tb_usb_packet_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_active;
    logic       rx_valid;
    logic       rx_error;
    logic [6:0] dev_address;

    logic [3:0] pid, pid_16;
    logic       pid_valid, pid_valid_16;
    logic [6:0] address, address_16;
    logic [3:0] end_point, end_point_16;
    logic       token_valid, token_valid_16;
    logic [7:0] data_o, data_o_16;
    logic       data_o_valid, data_o_valid_16;
    logic [3:0] data_len, data_len_16;
    logic       data_done, data_done_16;
    logic       crc_error, crc_error_16;
    logic       pid_error, pid_error_16;
    logic       pkt_error, pkt_error_16;

    usb_packet_decoder dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_active(rx_active),
        .rx_valid(rx_valid), .rx_error(rx_error), .dev_address(dev_address),
        .pid(pid), .pid_valid(pid_valid), .address(address), .end_point(end_point),
        .token_valid(token_valid), .data_o(data_o), .data_o_valid(data_o_valid),
        .data_len(data_len), .data_done(data_done), .crc_error(crc_error),
        .pid_error(pid_error), .pkt_error(pkt_error)
    );

    usb_packet_decoder #(.NUM_ENDPOINTS(16)) dut16 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_active(rx_active),
        .rx_valid(rx_valid), .rx_error(rx_error), .dev_address(dev_address),
        .pid(pid_16), .pid_valid(pid_valid_16), .address(address_16), .end_point(end_point_16),
        .token_valid(token_valid_16), .data_o(data_o_16), .data_o_valid(data_o_valid_16),
        .data_len(data_len_16), .data_done(data_done_16), .crc_error(crc_error_16),
        .pid_error(pid_error_16), .pkt_error(pkt_error_16)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int n_pid, n_tok, n_data, n_done, n_crc, n_pid_err, n_pkt;
    int n_tok16, n_err16;
    int pkt_at, byte_idx;
    logic [3:0] last_len;
    logic [7:0] cap [0:15];
    logic [7:0] pkt [0:15];

    always @(negedge clk) begin
        if (pid_valid)   n_pid++;
        if (token_valid) n_tok++;
        if (data_o_valid) begin
            if (n_data < 16) cap[n_data] = data_o;
            n_data++;
        end
        if (data_done) begin
            n_done++;
            last_len = data_len;
        end
        if (crc_error) n_crc++;
        if (pid_error) n_pid_err++;
        if (pkt_error) begin
            n_pkt++;
            pkt_at = byte_idx;
        end
        if (token_valid_16) n_tok16++;
        if (crc_error_16 || pid_error_16 || pkt_error_16) n_err16++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        n_pid = 0; n_tok = 0; n_data = 0; n_done = 0; n_crc = 0; n_pid_err = 0; n_pkt = 0;
        n_tok16 = 0; n_err16 = 0; pkt_at = -1; byte_idx = -1; last_len = 4'hF;
        for (int i = 0; i < 16; i++) cap[i] = 8'hXX;
    endtask

    function automatic logic [4:0] crc5_calc(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 5'b10100) : (c >> 1);
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_add(input logic [15:0] c0, input logic [7:0] d);
        logic [15:0] c;
        c = c0;
        for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    task automatic mk_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input bit bad);
        logic [4:0] c;
        c = crc5_calc({e, a});
        if (bad) c[0] = ~c[0];
        pkt[0] = {~p, p};
        pkt[1] = {e[0], a};
        pkt[2] = {c, e[3:1]};
    endtask

    // Payload bytes are 0,1,2,...; returns total packet length including PID and CRC16.
    task automatic mk_data(input logic [3:0] p, input int n, output int len);
        logic [15:0] c;
        c = 16'hFFFF;
        pkt[0] = {~p, p};
        for (int i = 0; i < n; i++) begin
            pkt[i+1] = 8'(i);
            c = crc16_add(c, 8'(i));
        end
        c = ~c;
        pkt[n+1] = c[7:0];
        pkt[n+2] = c[15:8];
        len = n + 3;
    endtask

    task automatic send_bytes(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            rx_data  = pkt[i];
            rx_valid = 1'b1;
            byte_idx = i;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pkt(input int n);
        rx_active = 1'b1;
        @(posedge clk); #1;
        send_bytes(0, n);
        rx_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    int len;

    initial begin
        reset = 1'b0; rx_data = '0; rx_active = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
        dev_address = 7'h15;
        clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_tok",  {15'd0, pid, pid_valid, address, end_point, token_valid}, 32'd0);
        check("rst_data", {15'd0, data_o, data_o_valid, data_len, data_done, crc_error, pid_error, pkt_error}, 32'd0);
        check("rst_16",   {20'd0, pid_16, address_16, token_valid_16}, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // SETUP addr 0x15 endp 0xE: accepted only by the 16-endpoint instance
        clear(); mk_token(4'hD, 7'h15, 4'hE, 1'b0); send_pkt(3);
        check("tok_pid",     pid_16, 4'hD);
        check("tok_valid16", n_tok16, 1);
        check("tok_addr16",  address_16, 7'h15);
        check("tok_ep16",    end_point_16, 4'hE);
        check("tok_err16",   n_err16, 0);
        check("tok_ep_drop", n_tok, 0);
        check("tok_ep_err",  n_crc + n_pid_err + n_pkt, 0);

        clear(); dev_address = 7'h3A; mk_token(4'hD, 7'h15, 4'hE, 1'b0); send_pkt(3);
        check("afilt_tok",  n_tok16, 0);
        check("afilt_err",  n_err16, 0);
        check("afilt_hold", address_16, 7'h15);
        dev_address = 7'h15;

        clear(); mk_token(4'h1, 7'h15, 4'h4, 1'b0); send_pkt(3);
        check("efilt_tok", n_tok, 0);
        check("efilt_err", n_crc + n_pid_err + n_pkt, 0);

        clear(); mk_token(4'h9, 7'h15, 4'h1, 1'b0); send_pkt(3);
        check("ep1_tok",  n_tok, 1);
        check("ep1_addr", address, 7'h15);
        check("ep1_ep",   end_point, 4'h1);
        check("ep1_pid",  pid, 4'h9);

        clear(); mk_token(4'h1, 7'h15, 4'h1, 1'b1); send_pkt(3);
        check("crc5_err", n_crc, 1);
        check("crc5_tok", n_tok, 0);

        clear(); mk_data(4'h3, 4, len); send_pkt(len);
        check("data_cnt",   n_data, 4);
        check("data_bytes", {cap[0], cap[1], cap[2], cap[3]}, 32'h00010203);
        check("data_done",  n_done, 1);
        check("data_len",   last_len, 4);
        check("data_crc",   n_crc, 0);
        check("data_pid",   pid, 4'h3);

        clear(); mk_data(4'h3, 4, len); pkt[5] = pkt[5] ^ 8'h01; send_pkt(len);
        check("bcrc_cnt",  n_data, 4);
        check("bcrc_done", n_done, 1);
        check("bcrc_err",  n_crc, 1);

        clear(); pkt[0] = 8'h2C; pkt[1] = 8'h00; pkt[2] = 8'h01; send_pkt(3);
        check("piderr_err",   n_pid_err, 1);
        check("piderr_valid", n_pid, 0);
        check("piderr_other", n_data + n_done + n_pkt + n_tok + n_crc, 0);

        clear(); pkt[0] = 8'hD2; send_pkt(1);
        check("ack_pid",   pid, 4'h2);
        check("ack_valid", n_pid, 1);
        check("ack_other", n_tok + n_data + n_done + n_crc + n_pid_err + n_pkt, 0);

        clear(); pkt[0] = 8'hD2; pkt[1] = 8'h00; send_pkt(2);
        check("hs_extra", n_pkt, 1);

        clear(); mk_data(4'hB, 9, len); send_pkt(len);
        check("ovf_pkt",  n_pkt, 1);
        check("ovf_at",   pkt_at, 11);
        check("ovf_done", n_done, 0);
        check("ovf_data", n_data, 8);

        clear(); mk_data(4'h3, 0, len); send_pkt(len);
        check("zlp_done", n_done, 1);
        check("zlp_len",  last_len, 0);
        check("zlp_crc",  n_crc, 0);
        check("zlp_data", n_data, 0);

        clear(); pkt[0] = 8'hC3; pkt[1] = 8'h00; send_pkt(2);
        check("short_pkt",  n_pkt, 1);
        check("short_done", n_done, 0);

        // rx_error between the two token bytes
        clear(); mk_token(4'h9, 7'h15, 4'h1, 1'b0);
        rx_active = 1'b1; @(posedge clk); #1;
        send_bytes(0, 2);
        rx_error = 1'b1; @(posedge clk); #1; rx_error = 1'b0;
        send_bytes(2, 1);
        rx_active = 1'b0; repeat (3) @(posedge clk); #1;
        check("rxerr_pkt", n_pkt, 1);
        check("rxerr_tok", n_tok, 0);

        // async reset in the middle of a data packet, released while still active
        clear(); mk_data(4'h3, 4, len);
        rx_active = 1'b1; @(posedge clk); #1;
        send_bytes(0, 4);
        #2 reset = 1'b0;
        #1;
        check("arst_pid",  pid, 4'h0);
        check("arst_addr", {address, end_point}, 11'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        clear();
        send_bytes(4, len - 4);
        rx_active = 1'b0; repeat (3) @(posedge clk); #1;
        check("arst_drop", n_pid + n_data + n_done + n_pkt + n_crc + n_pid_err, 0);
        clear(); mk_data(4'h3, 4, len); send_pkt(len);
        check("arst_next_done", n_done, 1);
        check("arst_next_len",  last_len, 4);
        check("arst_next_data", n_data, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
